// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame sprite position, jump FSM and walk animation; optional PLAYER_MOTION_FACING_EN adds facing_left
module player_motion_ctrl #(
    parameter int X_MIN       = 1,
    parameter int X_MAX       = 894,
    parameter int Y_GROUND    = 430,
    parameter int JUMP_HEIGHT = 80,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 4,
    parameter int ANIM_DIV    = 8,
    parameter int N_FRAMES    = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        enable,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic [1:0]  anim_frame,
    output logic [1:0]  state
`ifdef PLAYER_MOTION_FACING_EN
   ,output logic        facing_left
`endif
);
    typedef enum logic [1:0] {IDLE, WALK, RISE, FALL} state_t;
    localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(ANIM_DIV - 1);
    localparam logic [1:0] FR_MAX = 2'(N_FRAMES - 1);
    localparam logic signed [11:0] XMN = 12'(X_MIN);
    localparam logic signed [11:0] XMX = 12'(X_MAX);
    localparam logic signed [11:0] SX = 12'(STEP_X);
    localparam logic signed [11:0] SY = 12'(STEP_Y);
    localparam logic signed [11:0] YGND = 12'(Y_GROUND);
    localparam logic signed [11:0] YTOP = 12'(Y_GROUND - JUMP_HEIGHT);
    state_t st;
    logic vblnk_d, tick, lr;
    logic [DW-1:0] div_cnt;
    logic signed [11:0] dx, nx, xc, yu, yd;
    assign state = st;
    // frame tick detection and next-position arithmetic in signed 12 bits so edges clamp instead of wrapping
    always_comb begin
        tick = vblnk & ~vblnk_d & enable;
        lr = btn_left ^ btn_right;
        dx = (btn_right & ~btn_left) ? SX : (btn_left & ~btn_right) ? -SX : 12'sd0;
        nx = $signed({1'b0, xpos}) + dx;
        xc = nx < XMN ? XMN : nx > XMX ? XMX : nx;
        yu = $signed({1'b0, ypos}) - SY;
        yd = $signed({1'b0, ypos}) + SY;
    end
    // all motion state advances once per enabled vblank rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            xpos       <= 11'(X_MIN);
            ypos       <= 11'(Y_GROUND);
            anim_frame <= 2'd0;
            div_cnt    <= '0;
            st         <= IDLE;
        end else begin
            vblnk_d <= vblnk;
            if (tick) begin
                xpos <= xc[10:0];
                case (st)
                    IDLE: begin
                        st         <= btn_jump ? RISE : lr ? WALK : IDLE;
                        anim_frame <= 2'd0;
                        div_cnt    <= '0;
                    end
                    WALK: begin
                        st      <= btn_jump ? RISE : lr ? WALK : IDLE;
                        div_cnt <= div_cnt == DIV_MAX ? '0 : div_cnt + 1'b1;
                        if (div_cnt == DIV_MAX) anim_frame <= anim_frame == FR_MAX ? 2'd0 : anim_frame + 2'd1;
                    end
                    RISE: begin
                        ypos <= yu <= YTOP ? YTOP[10:0] : yu[10:0];
                        if (yu <= YTOP) st <= FALL;
                    end
                    FALL: begin
                        ypos <= yd >= YGND ? YGND[10:0] : yd[10:0];
                        if (yd >= YGND) st <= lr ? WALK : IDLE;
                    end
                endcase
            end
        end
    end
`ifdef PLAYER_MOTION_FACING_EN
    // facing follows the last single-direction press seen on an enabled tick
    always_ff @(posedge clk) begin
        if (rst) facing_left <= 1'b0;
        else if (tick && lr) facing_left <= btn_left;
    end
`endif
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed table and sequence checks for player_motion_ctrl
module tb_player_motion_ctrl;
    logic clk = 0, rst = 1, vblnk = 0, enable = 1, btn_left = 0, btn_right = 0, btn_jump = 0;
    logic [10:0] xpos, ypos;
    logic [1:0] anim_frame, state;
`ifdef PLAYER_MOTION_FACING_EN
    logic facing_left;
`endif
    int checks = 0, failures = 0;
    typedef struct {
        logic l, r, j, en;
        int x, y, st, fr;
    } vec_t;
    vec_t tv[$];

    player_motion_ctrl dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .xpos(xpos), .ypos(ypos), .anim_frame(anim_frame), .state(state)
`ifdef PLAYER_MOTION_FACING_EN
       ,.facing_left(facing_left)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic frame(input int hi);
        @(negedge clk) vblnk = 1;
        repeat (hi) @(negedge clk);
        vblnk = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic btns(input logic l, input logic r, input logic j);
        btn_left = l; btn_right = r; btn_jump = j;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1, 430, 0, 0});
        for (int i = 1; i <= 10; i++) tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1 + 2 * i, 430, 1, (i >= 9) ? 1 : 0});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 21, 430, 0, 1});
        tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 21, 430, 0, 0});
        tv.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 21, 430, 0, 0});
        tv.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 21, 430, 0, 0});
        for (int i = 0; i < 5; i++) tv.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 21, 430, 0, 0});
        tv.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 23, 430, 1, 0});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 21, 430, 1, 0});

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_x", 32'(xpos), 1);
        chk("reset_y", 32'(ypos), 430);
        chk("reset_state", 32'(state), 0);
        chk("reset_frame", 32'(anim_frame), 0);
`ifdef PLAYER_MOTION_FACING_EN
        chk("reset_facing", 32'(facing_left), 0);
`endif

        foreach (tv[i]) begin
            btns(tv[i].l, tv[i].r, tv[i].j);
            enable = tv[i].en;
            frame(1);
            chk($sformatf("vec%0d_x", i), 32'(xpos), 32'(tv[i].x));
            chk($sformatf("vec%0d_y", i), 32'(ypos), 32'(tv[i].y));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].st));
            chk($sformatf("vec%0d_frame", i), 32'(anim_frame), 32'(tv[i].fr));
        end
        enable = 1;
`ifdef PLAYER_MOTION_FACING_EN
        chk("facing_after_left", 32'(facing_left), 1);
        btns(1, 1, 0); frame(1);
        chk("facing_both_held", 32'(facing_left), 1);
        btns(0, 1, 0); enable = 0; frame(1); enable = 1;
        chk("facing_frozen", 32'(facing_left), 1);
        btns(1, 0, 0); frame(1);
`endif

        btns(1, 0, 0);
        while (xpos > 5 && checks < 10000) begin
            frame(1);
            checks++;
        end
        chk("left_reach5", 32'(xpos), 5);
        for (int i = 0; i < 4; i++) begin
            frame(1);
            chk($sformatf("clamp%0d_x", i), 32'(xpos), (i == 0) ? 3 : 1);
            chk($sformatf("clamp%0d_state", i), 32'(state), 1);
        end
        btns(0, 0, 0); frame(1); frame(1);
        chk("idle_before_jump", 32'(state), 0);

        btns(0, 0, 1); frame(1);
        chk("jump_start_state", 32'(state), 2);
        chk("jump_start_y", 32'(ypos), 430);
        btns(0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            btn_jump = (i >= 5 && i <= 8);
            frame(1);
            chk($sformatf("rise%0d_y", i), 32'(ypos), 32'(430 - 4 * i));
            chk($sformatf("rise%0d_state", i), 32'(state), (i < 20) ? 2 : 3);
        end
        for (int i = 1; i <= 20; i++) begin
            btn_jump = (i >= 5 && i <= 8);
            frame(1);
            chk($sformatf("fall%0d_y", i), 32'(ypos), 32'(350 + 4 * i));
            chk($sformatf("fall%0d_state", i), 32'(state), (i < 20) ? 3 : 0);
        end
        btn_jump = 0;
        chk("jump_x", 32'(xpos), 1);

        btns(0, 1, 0);
        frame(5);
        chk("held_vblnk_x1", 32'(xpos), 3);
        frame(4);
        chk("held_vblnk_x2", 32'(xpos), 5);

        btns(0, 0, 1); frame(1);
        btns(0, 0, 0); frame(1); frame(1);
        chk("midjump_y", 32'(ypos), 422);
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        chk("rst_mid_y", 32'(ypos), 430);
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_x", 32'(xpos), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
